// File: rtl/core_mem_pkg.sv
// Shared constants and request-kind type for the arbitrated RAM block.
package core_mem_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } req_kind_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin single-grant arbiter; search starts at the pointer and wraps to 0.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] valid_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic              grant_any_o
);

    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  ptr_d;
    logic [IDX_W-1:0]  win_idx;
    logic [NUM_CH-1:0] grant;
    logic              found;

    // Two passes: channels at/after the pointer first, then the wrapped ones.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        win_idx = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!found && valid_i[c] && (c >= 32'(ptr_q))) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                win_idx  = IDX_W'(c);
            end
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!found && valid_i[c] && (c < 32'(ptr_q))) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                win_idx  = IDX_W'(c);
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (32'(win_idx) == NUM_CH - 1) ? '0 : win_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o     = grant;
    assign grant_any_o = found;

endmodule

// File: rtl/multi_port_ram_arb.sv
// Multi-channel RAM with round-robin access, latency-1 read responses and a read-first
// observation port. Define ARB_STATS_EN to build the saturating per-channel grant counters.
module multi_port_ram_arb
    import core_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_CH = 2
) (
    input  logic                     ExternalClk,
    input  logic                     ExternalRstN,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        DoutB,
    output logic [NUM_CH*CNT_W-1:0]  grant_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [NUM_CH-1:0] grant;
    logic              grant_any;
    req_kind_e         sel_kind;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              wr_hs;
    logic              rd_hs;
    logic [NUM_CH-1:0] rsp_valid_d;
    logic [NUM_CH-1:0] rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [DATA_W-1:0] doutb_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk_i       (ExternalClk),
        .rst_ni      (ExternalRstN),
        .valid_i     (req_valid),
        .grant_o     (grant),
        .grant_any_o (grant_any)
    );

    assign req_ready = grant;

    // Mux the winning channel's request onto the RAM port.
    always_comb begin
        sel_kind  = RD;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                sel_kind  = req_kind_e'(req_we[c]);
                sel_addr  = req_addr[c*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[c*DATA_W +: DATA_W];
            end
        end
    end

    assign wr_hs       = grant_any && (sel_kind == WR);
    assign rd_hs       = grant_any && (sel_kind == RD);
    assign rsp_valid_d = rd_hs ? grant : '0;

    always_ff @(posedge ExternalClk) begin
        if (wr_hs) begin
            mem_q[sel_addr] <= sel_wdata;
        end
    end

    // Both read ports sample the array before this edge's write lands (read-first).
    always_ff @(posedge ExternalClk or negedge ExternalRstN) begin
        if (!ExternalRstN) begin
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            doutb_q     <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (rd_hs) begin
                rsp_rdata_q <= mem_q[sel_addr];
            end
            doutb_q <= mem_q[dbg_addr];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign DoutB     = doutb_q;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    always_ff @(posedge ExternalClk or negedge ExternalRstN) begin
        if (!ExternalRstN) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (grant[c] && (cnt_q[c] != {CNT_W{1'b1}})) begin
                    cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_port_ram_arb.sv
// Directed bench for multi_port_ram_arb: vector table plus hand-written corner sequences.
module tb_multi_port_ram_arb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic [7:0]  dbg_addr;
    logic [15:0] DoutB;
    logic [31:0] grant_cnt;

    int total = 0;
    int bad   = 0;

    multi_port_ram_arb #(
        .DATA_W (16),
        .ADDR_W (8),
        .NUM_CH (2)
    ) dut (
        .ExternalClk  (clk),
        .ExternalRstN (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .dbg_addr     (dbg_addr),
        .DoutB        (DoutB),
        .grant_cnt    (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [7:0]  dbg;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_rsp;
        logic [15:0] exp_rd;
        logic        chk_db;
        logic [15:0] exp_db;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [7:0] dbg);
        req_valid = v;
        req_we    = w;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        dbg_addr  = dbg;
    endtask

    initial begin
        // valid we a0 a1 d0 d1 dbg | ready rsp rdata chk_db doutb
        vecs[0] = '{2'b01, 2'b01, 8'h05, 8'h00, 16'h1234, 16'h0000, 8'h05, 2'b01, 2'b00, 16'h0000, 1'b0, 16'h0000};
        vecs[1] = '{2'b01, 2'b00, 8'h05, 8'h00, 16'h0000, 16'h0000, 8'h05, 2'b01, 2'b01, 16'h1234, 1'b1, 16'h1234};
        vecs[2] = '{2'b10, 2'b10, 8'h00, 8'h10, 16'h0000, 16'h0001, 8'h05, 2'b10, 2'b00, 16'h1234, 1'b1, 16'h1234};
        vecs[3] = '{2'b11, 2'b11, 8'h20, 8'h21, 16'hAAAA, 16'h5555, 8'h10, 2'b01, 2'b00, 16'h1234, 1'b1, 16'h0001};
        vecs[4] = '{2'b11, 2'b11, 8'h20, 8'h21, 16'hAAAA, 16'h5555, 8'h20, 2'b10, 2'b00, 16'h1234, 1'b1, 16'hAAAA};
        vecs[5] = '{2'b11, 2'b00, 8'h20, 8'h21, 16'h0000, 16'h0000, 8'h21, 2'b01, 2'b01, 16'hAAAA, 1'b1, 16'h5555};
        vecs[6] = '{2'b11, 2'b00, 8'h20, 8'h21, 16'h0000, 16'h0000, 8'h05, 2'b10, 2'b10, 16'h5555, 1'b1, 16'h1234};
        vecs[7] = '{2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 8'h10, 2'b00, 2'b00, 16'h5555, 1'b1, 16'h0001};

        rst_n = 1'b0;
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("reset rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("reset DoutB", 32'(DoutB), 32'h0);
        check("reset grant_cnt", grant_cnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].valid, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1, vecs[i].dbg);
            #2;
            check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rsp));
            check($sformatf("vec%0d rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].exp_rd));
            if (vecs[i].chk_db) begin
                check($sformatf("vec%0d DoutB", i), 32'(DoutB), 32'(vecs[i].exp_db));
            end
        end

        // Contention: both channels read continuously, pointer starts at 0.
        drive(2'b11, 2'b00, 8'h20, 8'h21, 16'h0000, 16'h0000, 8'h00);
        for (int k = 0; k < 6; k++) begin
            #2;
            check($sformatf("contend%0d ready", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            @(posedge clk);
            #1;
            check($sformatf("contend%0d rsp_valid", k), 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("contend%0d rsp_rdata", k), 32'(rsp_rdata), (k % 2 == 0) ? 32'hAAAA : 32'h5555);
        end

        // Only ch1 for three cycles, then both: pointer wrapped to ch0.
        drive(2'b10, 2'b00, 8'h20, 8'h21, 16'h0000, 16'h0000, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #2;
            check($sformatf("hold%0d ready", k), 32'(req_ready), 32'h2);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d rsp_valid", k), 32'(rsp_valid), 32'h2);
        end
        drive(2'b11, 2'b00, 8'h20, 8'h21, 16'h0000, 16'h0000, 8'h00);
        #2;
        check("hold both ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        check("hold both rsp_rdata", 32'(rsp_rdata), 32'hAAAA);

        // Write/observe collision: old data first, new data one cycle later.
        drive(2'b01, 2'b01, 8'h10, 8'h00, 16'hBEEF, 16'h0000, 8'h10);
        #2;
        check("collide ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        check("collide DoutB old", 32'(DoutB), 32'h0001);
        check("collide no rsp", 32'(rsp_valid), 32'h0);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 8'h10);
        @(posedge clk);
        #1;
        check("collide DoutB new", 32'(DoutB), 32'hBEEF);

        // Reset asserted in a read-handshake cycle (pointer is 1 beforehand).
        drive(2'b01, 2'b00, 8'h05, 8'h00, 16'h0000, 16'h0000, 8'h10);
        #2;
        check("rstmid ready", 32'(req_ready), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid DoutB immediate", 32'(DoutB), 32'h0);
        @(posedge clk);
        #1;
        check("rstmid rsp_valid", 32'(rsp_valid), 32'h0);
        check("rstmid rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("rstmid DoutB", 32'(DoutB), 32'h0);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 8'h05);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid no late rsp", 32'(rsp_valid), 32'h0);
        check("rstmid DoutB after", 32'(DoutB), 32'h1234);
        drive(2'b11, 2'b00, 8'h05, 8'h10, 16'h0000, 16'h0000, 8'h00);
        #2;
        check("rstmid ptr zero", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        check("rstmid ram kept", 32'(rsp_rdata), 32'h1234);
        check("rstmid rsp ch0", 32'(rsp_valid), 32'h1);

`ifdef ARB_STATS_EN
        drive(2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 8'h00);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("stats reset", grant_cnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b01, 2'b00, 8'h05, 8'h00, 16'h0000, 16'h0000, 8'h00);
        @(posedge clk);
        #1;
        check("stats first", grant_cnt, 32'h0000_0001);
        repeat (69999) @(posedge clk);
        #1;
        check("stats ch0 sat", {16'h0, grant_cnt[15:0]}, 32'hFFFF);
        check("stats ch1 zero", {16'h0, grant_cnt[31:16]}, 32'h0);
`else
        check("stats tied off", grant_cnt, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
